// File: rtl/restoring_divider_n.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk_i/rst_i, start_i + operands in; busy/done, quotient, remainder, div-by-zero out.

module subtractor_n #(
  parameter int nb_bit = 25
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

module restoring_divider_n #(
  parameter int nb_bit = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [nb_bit-1:0] dividend_i,
  input  logic [nb_bit-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] quotient_o,
  output logic [nb_bit-1:0] remainder_o,
  output logic              div_by_zero_o
);

  localparam int cnt_w = $clog2(nb_bit + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [cnt_w-1:0]  cnt;
  logic [nb_bit-1:0] q_reg;
  logic [nb_bit-1:0] d_reg;
  logic [nb_bit-1:0] r_reg;

  logic [nb_bit:0]   sub_diff;
  logic              sub_borrow;
  logic [nb_bit-1:0] q_next;
  logic [nb_bit-1:0] r_next;
  logic              unused_diff_msb;

  // One extra MSB keeps {R, Q[msb]} from overflowing when R >= 2^(nb_bit-1).
  subtractor_n #(
    .nb_bit(nb_bit + 1)
  ) u_sub (
    .a_i     ({r_reg, q_reg[nb_bit-1]}),
    .b_i     ({1'b0, d_reg}),
    .diff_o  (sub_diff),
    .borrow_o(sub_borrow)
  );

  // On borrow the shifted-in value is smaller than D, so it fits nb_bit bits;
  // without borrow the difference is smaller than D as well.
  assign r_next = sub_borrow ? {r_reg[nb_bit-2:0], q_reg[nb_bit-1]}
                             : sub_diff[nb_bit-1:0];
  assign q_next = {q_reg[nb_bit-2:0], ~sub_borrow};
  assign unused_diff_msb = sub_diff[nb_bit];

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start_i) begin
            if (divisor_i == '0) begin
              state         <= DONE;
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
            end else begin
              state         <= RUN;
              q_reg         <= dividend_i;
              d_reg         <= divisor_i;
              r_reg         <= '0;
              cnt           <= '0;
              div_by_zero_o <= 1'b0;
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + cnt_w'(1);
          if (cnt == cnt_w'(nb_bit - 1)) begin
            state       <= DONE;
            quotient_o  <= q_next;
            remainder_o <= r_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_n.sv
// Self-checking bench for restoring_divider_n.
// Random and directed divisions checked against plain / and % arithmetic.

module tb_restoring_divider_n;

  localparam int NB = 24;
  localparam logic [NB-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NB-1:0] dividend = '0;
  logic [NB-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [NB-1:0] quotient;
  logic [NB-1:0] remainder;
  logic          dbz;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  restoring_divider_n #(
    .nb_bit(NB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, all-ones / dividend for b == 0.
  function automatic void ref_div(input logic [NB-1:0] a,
                                  input logic [NB-1:0] b,
                                  output logic [NB-1:0] q,
                                  output logic [NB-1:0] r);
    if (b == '0) begin
      q = ONES;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drive a start now; it is taken on the next rising edge.
  task automatic start_op(input logic [NB-1:0] a, input logic [NB-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done after the accept edge; optionally pulses an extra
  // 50/5 start while busy at sample index inj.
  task automatic wait_done(input string tag, input logic [NB-1:0] a,
                           input logic [NB-1:0] b, input int inj,
                           input bit full);
    int lat;
    int nbusy;
    logic [NB-1:0] eq;
    logic [NB-1:0] er;
    lat = 0;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (lat == inj) begin
        start = 1'b1;
        dividend = 24'd50;
        divisor = 24'd5;
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
    end
    ref_div(a, b, eq, er);
    if (full) begin
      check({tag, "_lat"}, lat, (b == '0) ? 0 : NB);
      check({tag, "_busycyc"}, nbusy, (b == '0) ? 0 : NB);
      check({tag, "_busy_in_done"}, {31'd0, busy}, 0);
      check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, (b == '0)});
    end
    check({tag, "_q"}, {8'd0, quotient}, {8'd0, eq});
    check({tag, "_r"}, {8'd0, remainder}, {8'd0, er});
  endtask

  task automatic run_div(input string tag, input logic [NB-1:0] a,
                         input logic [NB-1:0] b, input bit full);
    start_op(a, b);
    wait_done(tag, a, b, -1, full);
  endtask

  // One idle edge after done: pulse gone, results held.
  task automatic hold_check(input string tag, input logic [NB-1:0] a,
                            input logic [NB-1:0] b);
    logic [NB-1:0] eq;
    logic [NB-1:0] er;
    ref_div(a, b, eq, er);
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, {31'd0, done}, 0);
    check({tag, "_q_hold"}, {8'd0, quotient}, {8'd0, eq});
    check({tag, "_r_hold"}, {8'd0, remainder}, {8'd0, er});
    check({tag, "_dbz_hold"}, {31'd0, dbz}, {31'd0, (b == '0)});
  endtask

  initial begin
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    bit seen;

    #1;
    check("reset_outs", {4'd0, busy, done, dbz, quotient}, 0);
    repeat (2) @(posedge clk);
    #1 check("reset_rem", {8'd0, remainder}, 0);
    @(negedge clk) rst = 1'b0;

    run_div("basic", 24'd100, 24'd7, 1);
    hold_check("basic", 24'd100, 24'd7);

    run_div("max_by1", ONES, 24'd1, 1);
    run_div("small", 24'd5, 24'd9, 1);
    run_div("max_max", ONES, ONES, 1);

    run_div("dbz", 24'd1234, 24'd0, 1);
    hold_check("dbz", 24'd1234, 24'd0);
    run_div("after_dbz", 24'd10, 24'd3, 1);

    start_op(24'd100, 24'd7);
    wait_done("ignore", 24'd100, 24'd7, 3, 1);
    // Back-to-back: start raised in the done cycle.
    run_div("b2b", 24'd50, 24'd5, 1);
    hold_check("b2b", 24'd50, 24'd5);

    start_op(24'd100, 24'd7);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("abort_outs", {4'd0, busy, done, dbz, quotient}, 0);
    check("abort_rem", {8'd0, remainder}, 0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    run_div("after_rst", 24'd100, 24'd7, 1);

    for (int i = 0; i < 2000; i++) begin
      a = NB'($urandom);
      b = (i % 3 == 0) ? NB'($urandom_range(1, 255)) : NB'($urandom);
      if (i % 7 == 0) a = a >> $urandom_range(0, NB - 1);
      if (b == '0) b = 24'd1;
      run_div("rnd", a, b, (i % 50 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
